// File: rtl/ct_ifu_ibuf_ptr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ct_ifu_ibuf_pkg
// Brief    : Shared sizes, types and helpers for the IFU inst buffer pointers.
// Revision : 1.0  initial release
// ============================================================================
package ct_ifu_ibuf_pkg;

  localparam int IBUF_ENTRY_NUM = 32;
  localparam int IBUF_PUSH_MAX  = 8;
  localparam int IBUF_POP_MAX   = 6;

  localparam int PTR_W      = $clog2(IBUF_ENTRY_NUM);
  localparam int CNT_W      = PTR_W + 1;
  localparam int PUSH_NUM_W = $clog2(IBUF_PUSH_MAX + 1);
  localparam int POP_NUM_W  = $clog2(IBUF_POP_MAX + 1);

  typedef logic [PTR_W-1:0]          ibuf_ptr_t;
  typedef logic [CNT_W-1:0]          ibuf_cnt_t;
  typedef logic [IBUF_ENTRY_NUM-1:0] ibuf_vec_t;
  typedef logic [PUSH_NUM_W-1:0]     push_num_t;
  typedef logic [POP_NUM_W-1:0]      pop_num_t;

  // Retire request limited to what is actually held, so the count never underflows.
  function automatic ibuf_cnt_t ibuf_pop_clamp(input pop_num_t pop, input ibuf_cnt_t cnt);
    ibuf_cnt_t p;
    p = ibuf_cnt_t'(pop);
    return (p > cnt) ? cnt : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ct_ifu_ibuf_ptr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ct_ifu_ibuf_ptr_ctrl_if
// Brief    : Push/pop request and entry-array control bundle of the inst buffer.
// Revision : 1.0  initial release
// ============================================================================
import ct_ifu_ibuf_pkg::*;

interface ct_ifu_ibuf_ptr_ctrl_if;

  logic      ibuf_flush;
  logic      push_vld;
  push_num_t push_num;
  logic      push_accept;
  pop_num_t  pop_num;
  ibuf_vec_t entry_create_x;
  ibuf_vec_t entry_retire_x;
  ibuf_vec_t entry_create_clk_en_x;
  ibuf_vec_t entry_retire_clk_en_x;
  ibuf_ptr_t create_ptr;
  ibuf_ptr_t retire_ptr;
  ibuf_cnt_t entry_cnt;
  logic      ibuf_empty;
  logic      ibuf_full;

  // Requester side (IP stage / decode).
  modport master (
    output ibuf_flush, push_vld, push_num, pop_num,
    input  push_accept, entry_create_x, entry_retire_x,
           entry_create_clk_en_x, entry_retire_clk_en_x,
           create_ptr, retire_ptr, entry_cnt, ibuf_empty, ibuf_full
  );

  // Pointer controller side.
  modport slave (
    input  ibuf_flush, push_vld, push_num, pop_num,
    output push_accept, entry_create_x, entry_retire_x,
           entry_create_clk_en_x, entry_retire_clk_en_x,
           create_ptr, retire_ptr, entry_cnt, ibuf_empty, ibuf_full
  );

endinterface
`default_nettype wire

// File: rtl/ct_ifu_ibuf_ptr_ctrl_win_mask.sv
`default_nettype none
// ============================================================================
// Module   : ct_ifu_ibuf_win_mask
// Brief    : Rotated thermometer: bits ptr .. ptr+num-1 (mod ENTRY_NUM) set.
// Revision : 1.0  initial release
// ============================================================================
module ct_ifu_ibuf_win_mask #(
  parameter int ENTRY_NUM = 32,
  parameter int NUM_W     = 4
) (
  input  wire logic [$clog2(ENTRY_NUM)-1:0] i_ptr,
  input  wire logic [NUM_W-1:0]             i_num,
  output logic      [ENTRY_NUM-1:0]         o_mask
);

  localparam int PTR_W = $clog2(ENTRY_NUM);
  localparam int CMP_W = PTR_W + NUM_W;

  // Distance from the window start wraps naturally because ENTRY_NUM is a power of 2.
  for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_bit
    logic [PTR_W-1:0] w_off;
    assign w_off      = PTR_W'(gi) - i_ptr;
    assign o_mask[gi] = (CMP_W'(w_off) < CMP_W'(i_num));
  end

endmodule
`default_nettype wire

// File: rtl/ct_ifu_ibuf_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ct_ifu_ibuf_ptr_ctrl
// Brief    : Create/retire pointers, occupancy and per-entry strobes of the
//            IFU inst buffer. Option macro: IBUF_POP_CREDIT_EN.
// Revision : 1.0  initial release
// ============================================================================
import ct_ifu_ibuf_pkg::*;

module ct_ifu_ibuf_ptr_ctrl (
  input wire logic               forever_cpuclk,
  input wire logic               cpurst,
  ct_ifu_ibuf_ptr_ctrl_if.slave  ibuf_if
);

  localparam int FREE_W = PTR_W + 2;
  localparam logic [FREE_W-1:0] c_entry_num = FREE_W'(IBUF_ENTRY_NUM);
  localparam push_num_t         c_push_win  = push_num_t'(IBUF_PUSH_MAX);
  localparam pop_num_t          c_pop_win   = pop_num_t'(IBUF_POP_MAX);

  ibuf_ptr_t r_create_ptr;
  ibuf_ptr_t r_retire_ptr;
  ibuf_cnt_t r_entry_cnt;
  logic      r_empty;
  logic      r_full;

  ibuf_cnt_t         w_pop_eff;
  logic [FREE_W-1:0] w_free;
  logic              w_push_accept;
  push_num_t         w_create_num;
  pop_num_t          w_retire_num;
  push_num_t         w_cce_num;
  pop_num_t          w_rce_num;
  ibuf_cnt_t         w_cnt_nxt;
  ibuf_vec_t         w_create_x;
  ibuf_vec_t         w_retire_x;
  ibuf_vec_t         w_create_clk_en_x;
  ibuf_vec_t         w_retire_clk_en_x;

  assign w_pop_eff = ibuf_pop_clamp(ibuf_if.pop_num, r_entry_cnt);

`ifdef IBUF_POP_CREDIT_EN
  // Space released by this cycle's retire may be refilled in the same cycle.
  assign w_free = c_entry_num - FREE_W'(r_entry_cnt) + FREE_W'(w_pop_eff);
`else
  assign w_free = c_entry_num - FREE_W'(r_entry_cnt);
`endif

  assign w_push_accept = ibuf_if.push_vld & ~ibuf_if.ibuf_flush & ~cpurst &
                         (FREE_W'(ibuf_if.push_num) <= w_free);

  assign w_create_num = w_push_accept ? ibuf_if.push_num : '0;
  assign w_retire_num = (ibuf_if.ibuf_flush | cpurst) ? '0 : pop_num_t'(w_pop_eff);

  // Clock-enable windows are full-width supersets so they avoid the accept compare.
  assign w_cce_num = (ibuf_if.push_vld & ~cpurst) ? c_push_win : '0;
  assign w_rce_num = ((ibuf_if.pop_num != '0) & ~cpurst) ? c_pop_win : '0;

  assign w_cnt_nxt = r_entry_cnt + ibuf_cnt_t'(w_create_num) - w_pop_eff;

  ct_ifu_ibuf_win_mask #(.ENTRY_NUM(IBUF_ENTRY_NUM), .NUM_W(PUSH_NUM_W)) u_create_win (
    .i_ptr  (r_create_ptr),
    .i_num  (w_create_num),
    .o_mask (w_create_x)
  );

  ct_ifu_ibuf_win_mask #(.ENTRY_NUM(IBUF_ENTRY_NUM), .NUM_W(POP_NUM_W)) u_retire_win (
    .i_ptr  (r_retire_ptr),
    .i_num  (w_retire_num),
    .o_mask (w_retire_x)
  );

  ct_ifu_ibuf_win_mask #(.ENTRY_NUM(IBUF_ENTRY_NUM), .NUM_W(PUSH_NUM_W)) u_create_ce_win (
    .i_ptr  (r_create_ptr),
    .i_num  (w_cce_num),
    .o_mask (w_create_clk_en_x)
  );

  ct_ifu_ibuf_win_mask #(.ENTRY_NUM(IBUF_ENTRY_NUM), .NUM_W(POP_NUM_W)) u_retire_ce_win (
    .i_ptr  (r_retire_ptr),
    .i_num  (w_rce_num),
    .o_mask (w_retire_clk_en_x)
  );

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_create_ptr <= '0;
      r_retire_ptr <= '0;
      r_entry_cnt  <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
    end else if (ibuf_if.ibuf_flush) begin
      r_create_ptr <= '0;
      r_retire_ptr <= '0;
      r_entry_cnt  <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
    end else begin
      r_create_ptr <= r_create_ptr + ibuf_ptr_t'(w_create_num);
      r_retire_ptr <= r_retire_ptr + ibuf_ptr_t'(w_pop_eff);
      r_entry_cnt  <= w_cnt_nxt;
      r_empty      <= (w_cnt_nxt == '0);
      r_full       <= (w_cnt_nxt == ibuf_cnt_t'(IBUF_ENTRY_NUM));
    end
  end

  assign ibuf_if.push_accept           = w_push_accept;
  assign ibuf_if.entry_create_x        = w_create_x;
  assign ibuf_if.entry_retire_x        = w_retire_x;
  assign ibuf_if.entry_create_clk_en_x = w_create_clk_en_x;
  assign ibuf_if.entry_retire_clk_en_x = w_retire_clk_en_x;
  assign ibuf_if.create_ptr            = r_create_ptr;
  assign ibuf_if.retire_ptr            = r_retire_ptr;
  assign ibuf_if.entry_cnt             = r_entry_cnt;
  assign ibuf_if.ibuf_empty            = r_empty;
  assign ibuf_if.ibuf_full             = r_full;

endmodule
`default_nettype wire

// File: tb/tb_ct_ifu_ibuf_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_ifu_ibuf_ptr_ctrl
// Brief    : Scoreboard bench; reference keeps the occupied entry ids in a queue.
// Revision : 1.0  initial release
// ============================================================================
import ct_ifu_ibuf_pkg::*;

module tb_ct_ifu_ibuf_ptr_ctrl;

  localparam int N = IBUF_ENTRY_NUM;

  logic forever_cpuclk = 1'b0;
  logic cpurst         = 1'b1;
  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_ifu_ibuf_ptr_ctrl_if ibuf_if();

  ct_ifu_ibuf_ptr_ctrl dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .ibuf_if        (ibuf_if.slave)
  );

  typedef struct {
    bit        known;
    bit        acc;
    ibuf_vec_t cr, rt, cce, rce;
    int        cptr, rptr, cnt;
    bit        empty, full;
  } exp_t;

  exp_t sb_q[$];
  int   occ_q[$];
  int   m_cptr  = 0;
  bit   m_known = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the reference predicts outputs, then advances.
  task automatic cyc(input bit rst, input bit fl, input bit pv, input int pn, input int pop);
    exp_t e;
    int   cnt, pop_eff, free, rptr;
    @(posedge forever_cpuclk);
    #1;
    cpurst             = rst;
    ibuf_if.ibuf_flush = fl;
    ibuf_if.push_vld   = pv;
    ibuf_if.push_num   = push_num_t'(pn);
    ibuf_if.pop_num    = pop_num_t'(pop);

    cnt     = occ_q.size();
    rptr    = (cnt != 0) ? occ_q[0] : m_cptr;
    pop_eff = (pop < cnt) ? pop : cnt;
`ifdef IBUF_POP_CREDIT_EN
    free = N - cnt + pop_eff;
`else
    free = N - cnt;
`endif
    e.known = m_known;
    e.cptr  = m_cptr;
    e.rptr  = rptr;
    e.cnt   = cnt;
    e.empty = (cnt == 0);
    e.full  = (cnt == N);
    e.acc   = pv && !fl && !rst && (pn <= free);
    e.cr = '0; e.rt = '0; e.cce = '0; e.rce = '0;
    if (e.acc)
      for (int k = 0; k < pn; k++) e.cr[(m_cptr + k) % N] = 1'b1;
    if (!fl && !rst)
      for (int k = 0; k < pop_eff; k++) e.rt[occ_q[k]] = 1'b1;
    if (pv && !rst)
      for (int k = 0; k < IBUF_PUSH_MAX; k++) e.cce[(m_cptr + k) % N] = 1'b1;
    if (pop != 0 && !rst)
      for (int k = 0; k < IBUF_POP_MAX; k++) e.rce[(rptr + k) % N] = 1'b1;
    sb_q.push_back(e);

    if (rst || fl) begin
      occ_q.delete();
      m_cptr = 0;
      if (rst) m_known = 1'b1;
    end else begin
      for (int k = 0; k < pop_eff; k++) void'(occ_q.pop_front());
      if (e.acc) begin
        for (int k = 0; k < pn; k++) occ_q.push_back((m_cptr + k) % N);
        m_cptr = (m_cptr + pn) % N;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge forever_cpuclk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("push_accept", longint'(ibuf_if.push_accept), longint'(e.acc));
        chk("entry_create_x", longint'(ibuf_if.entry_create_x), longint'(e.cr));
        chk("entry_retire_x", longint'(ibuf_if.entry_retire_x), longint'(e.rt));
        chk("create_clk_en", longint'(ibuf_if.entry_create_clk_en_x), longint'(e.cce));
        chk("retire_clk_en", longint'(ibuf_if.entry_retire_clk_en_x), longint'(e.rce));
        if (e.known) begin
          chk("create_ptr", longint'(ibuf_if.create_ptr), longint'(e.cptr));
          chk("retire_ptr", longint'(ibuf_if.retire_ptr), longint'(e.rptr));
          chk("entry_cnt", longint'(ibuf_if.entry_cnt), longint'(e.cnt));
          chk("ibuf_empty", longint'(ibuf_if.ibuf_empty), longint'(e.empty));
          chk("ibuf_full", longint'(ibuf_if.ibuf_full), longint'(e.full));
        end
      end
    end
  end

  initial begin : stimulus
    ibuf_if.ibuf_flush = 1'b0;
    ibuf_if.push_vld   = 1'b1;
    ibuf_if.push_num   = push_num_t'(8);
    ibuf_if.pop_num    = '0;

    // Reset held with a pending push.
    repeat (2) cyc(1, 0, 1, 8, 0);
    // Fill to full, then a one half-word push must bounce.
    repeat (4) cyc(0, 0, 1, 8, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Drain, then refill to leave create_ptr at 28 with an empty buffer.
    repeat (5) cyc(0, 0, 0, 1, 6);
    cyc(0, 0, 0, 1, 2);
    repeat (3) cyc(0, 0, 1, 8, 0);
    cyc(0, 0, 1, 4, 0);
    repeat (4) cyc(0, 0, 0, 1, 6);
    cyc(0, 0, 0, 1, 4);
    // Wrapping create window 28..3.
    cyc(0, 0, 1, 8, 0);
    // cnt 10 then simultaneous push/pop; drain through clamp.
    cyc(0, 0, 1, 2, 0);
    cyc(0, 0, 1, 8, 6);
    cyc(0, 0, 0, 1, 6);
    cyc(0, 0, 0, 1, 4);
    cyc(0, 0, 0, 1, 6);
    cyc(0, 0, 0, 1, 6);
    // Flush dominates push and pop at cnt 20.
    cyc(0, 0, 1, 8, 0);
    cyc(0, 0, 1, 8, 0);
    cyc(0, 0, 1, 4, 0);
    cyc(0, 1, 1, 8, 6);
    cyc(0, 0, 0, 1, 0);
    // cnt 30, push 4 with pop 4 exercises the pop-credit option.
    repeat (3) cyc(0, 0, 1, 8, 0);
    cyc(0, 0, 1, 6, 0);
    cyc(0, 0, 1, 4, 4);
    cyc(0, 0, 0, 1, 0);

    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0), int'($urandom_range(1, 8)),
          int'($urandom_range(0, 6)));
    end

    @(posedge forever_cpuclk);
    @(negedge forever_cpuclk);
    #1;
    chk("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
